sap_1_datapath: RTL



---
 rtl/sap_1_datapath.sv | 79 +++++++
 1 files changed

// File: rtl/sap_1_datapath.sv
// SAP-1 datapath: PC, MAR, 16x8 RAM, IR, A, B, adder/subtracter and OUT
// joined by the 8-bit W bus, driven by the sequencer's 12-bit control word.
module sap_1_datapath (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Cp,
  input  logic       Ep,
  input  logic       LMbar,
  input  logic       CEbar,
  input  logic       LIbar,
  input  logic       EIbar,
  input  logic       LAbar,
  input  logic       EA,
  input  logic       SU,
  input  logic       EU,
  input  logic       LBbar,
  input  logic       LObar,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [3:0] opcode,
  output logic [7:0] out_port,
  output logic [7:0] w_bus,
  output logic       bus_conflict
);

  logic [3:0] pc;
  logic [3:0] mar;
  logic [7:0] ir;
  logic [7:0] acc;
  logic [7:0] b_reg;
  logic [7:0] out_reg;
  logic [7:0] ram [16];
  logic [7:0] alu_result;
  logic [2:0] driver_count;

  // Subtraction is two's complement: A + ~B + 1, carry discarded.
  assign alu_result = acc + (SU ? ~b_reg : b_reg) + {7'b0000000, SU};

  always_comb begin
    w_bus = 8'h00;
    if (Ep)          w_bus = {4'h0, pc};
    else if (!CEbar) w_bus = ram[mar];
    else if (!EIbar) w_bus = {4'h0, ir[3:0]};
    else if (EA)     w_bus = acc;
    else if (EU)     w_bus = alu_result;
  end

  assign driver_count = {2'b00, Ep} + {2'b00, ~CEbar} + {2'b00, ~EIbar}
                      + {2'b00, EA} + {2'b00, EU};
  assign bus_conflict = (driver_count > 3'd1);

  // RAM is only written by the program port, and that port works even under reset.
  always_ff @(posedge Clk) begin
    if (prog_we) ram[prog_addr] <= prog_data;
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      pc      <= 4'h0;
      mar     <= 4'h0;
      ir      <= 8'h00;
      acc     <= 8'h00;
      b_reg   <= 8'h00;
      out_reg <= 8'h00;
    end else begin
      if (Cp)     pc      <= pc + 4'h1;
      if (!LMbar) mar     <= w_bus[3:0];
      if (!LIbar) ir      <= w_bus;
      if (!LAbar) acc     <= w_bus;
      if (!LBbar) b_reg   <= w_bus;
      if (!LObar) out_reg <= w_bus;
    end
  end

  assign opcode   = ir[7:4];
  assign out_port = out_reg;

endmodule
